// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int SEQ_MULT_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_datapath.sv
// Operand shift registers, 2*WIDTH accumulator and product register for the
// shift-add multiplier. Sequencing comes from seq_multiplier.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               capture,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               mplier_last,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;

  // NOTE: every always_comb output gets a value on every path (here the
  // default first) so no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  // High when the step in progress leaves no set bits in the multiplier.
  assign mplier_last = ((mplier >> 1) == '0);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // The product only moves on the final step, so it stays stable through BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product <= '0;
    end else if (capture) begin
      product <= acc_next;
    end
  end

endmodule : seq_mult_datapath

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: IDLE/BUSY/DONE FSM plus step counter.
// Define SEQ_MULT_EARLY_EXIT_EN to end BUSY once the multiplier runs out of set bits.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] step_cnt;
  logic          accept;
  logic          last_step;
  logic          mplier_last;

  // Start is only honoured outside BUSY; DONE may chain straight into BUSY.
  assign accept    = start && (state != BUSY);
  assign last_step = (step_cnt == LAST_STEP) || (EARLY_EXIT && mplier_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    state_next = accept ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (accept) begin
      step_cnt <= '0;
    end else if (state == BUSY) begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .step       (state == BUSY),
    .capture    ((state == BUSY) && last_step),
    .a          (a),
    .b          (b),
    .mplier_last(mplier_last),
    .product    (product)
  );

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=4) with a product scoreboard.
// Honours SEQ_MULT_EARLY_EXIT_EN for the expected BUSY length.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] sb[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_busy(input int bv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < W; i++) if (bv[i]) k = i + 1;
    return k;
`else
    return W;
`endif
  endfunction

  task automatic issue(input int av, input int bv);
    int p;
    @(negedge clk);
    start = 1'b1;
    a     = av[W-1:0];
    b     = bv[W-1:0];
    p     = av * bv;
    sb.push_back(p[2*W-1:0]);
  endtask

  // Called at the negedge of the first BUSY cycle; returns at the DONE negedge.
  task automatic wait_done(input int n0, input int exp_b, input string tag);
    int n = n0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, exp_b);
    check({tag, " done"}, done, 1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
    end else begin
      check({tag, " product"}, product, sb.pop_front());
    end
  endtask

  task automatic mult(input int av, input int bv, input int exp_b, input string tag);
    issue(av, bv);
    @(negedge clk);
    start = 1'b0;
    wait_done(0, exp_b, tag);
  endtask

  initial begin
    int pulses;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst product", product, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", busy, 0);

    // Largest operands, then one-cycle done and held product
    mult(15, 15, exp_busy(15), "max");
    @(negedge clk);
    check("max done_pulse", done, 0);
    check("max idle", busy, 0);
    repeat (3) @(negedge clk);
    check("max held", product, 225);

    // Exhaustive sweep
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        mult(ai, bi, exp_busy(bi), "sweep");

    // Back-to-back: start held through BUSY and DONE
    issue(9, 6);
    @(negedge clk);
    a = 4'd3;
    b = 4'd5;
    sb.push_back(8'd15);
    wait_done(0, exp_busy(6), "b2b_first");
    @(negedge clk);
    start = 1'b0;
    check("b2b no_gap busy", busy, 1);
    check("b2b no_gap done", done, 0);
    wait_done(0, exp_busy(5), "b2b_second");

    // Start pulsed mid-BUSY with other operands must be ignored
    @(negedge clk);
    issue(13, 11);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 4'd2;
    b     = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, exp_busy(11), "ignore");
    @(negedge clk);
    check("ignore idle busy", busy, 0);
    check("ignore idle done", done, 0);
    check("ignore held", product, 143);

    // Reset on the second BUSY cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort product", product, 0);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort no_done", pulses, 0);
    mult(6, 7, exp_busy(7), "post_reset");

`ifdef SEQ_MULT_EARLY_EXIT_EN
    mult(7, 1, 1, "ee_b1");
    mult(7, 8, 4, "ee_b8");
    mult(7, 0, 1, "ee_b0");
`endif

    check("sb drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001: Parameter WIDTH, default 4, operand width in bits; SHALL be legal for 2..32.
REQ-002: clk  input  1  single clock, all state updates on rising edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low.
REQ-004: start  input  1  request to begin a multiply, sampled on rising clk.
REQ-005: a  input  WIDTH  multiplicand, unsigned, sampled when start is accepted.
REQ-006: b  input  WIDTH  multiplier, unsigned, sampled when start is accepted.
REQ-007: busy  output  1  high while a multiply is in progress.
REQ-008: done  output  1  one-cycle pulse marking a valid new product.
REQ-009: product  output  2*WIDTH  unsigned a*b result, held until the next accepted start.

Function
REQ-010: FSM states SHALL be IDLE, BUSY and DONE.
REQ-011: Start SHALL be accepted only in IDLE or DONE; accepted start latches a and b, clears the accumulator and moves to BUSY on the next edge.
REQ-012: Start asserted in BUSY SHALL be ignored, with no effect on operands, state or count.
REQ-013: Each BUSY cycle SHALL be one shift-add step: if the multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH accumulator; then shift the multiplicand left and the multiplier right by one.
REQ-014: Without the early-exit feature, BUSY SHALL last exactly WIDTH cycles, counted by a step counter of width ceil(log2(WIDTH+1)).
REQ-015: Latency: start accepted at edge T -> busy high for cycles T+1..T+WIDTH -> done high and product valid at cycle T+WIDTH+1.
REQ-016: DONE SHALL last one cycle; without start it SHALL return to IDLE; with start it SHALL go straight to BUSY (back-to-back, no idle gap).
REQ-017: busy SHALL be high only in BUSY; done SHALL be high only in DONE.
REQ-018: product SHALL update only on entry to DONE and SHALL not glitch during BUSY.
REQ-019: The accumulator SHALL be 2*WIDTH bits wide so it never overflows; max result (2^WIDTH-1)^2.

Reset
REQ-020: rst_n low at a rising edge SHALL force IDLE, busy=0, done=0, product=0 and clear the operand, accumulator and counter registers.
REQ-021: Reset during BUSY SHALL abort the operation with no done pulse; the first start after reset release SHALL behave normally.

Configuration
REQ-022: Macro SEQ_MULT_EARLY_EXIT_EN, when defined, SHALL end BUSY after any step that leaves the remaining multiplier zero, entering DONE on the next edge.
REQ-023: With SEQ_MULT_EARLY_EXIT_EN defined, BUSY SHALL last 1 cycle for b=0 or b=1, k cycles for b whose highest set bit is bit k-1, and never more than WIDTH cycles.
REQ-024: Without the macro, latency SHALL be fixed per REQ-015 for every operand value.
REQ-025: The product value SHALL be identical with and without the macro.

Structure
REQ-026: Package seq_mult_pkg SHALL hold the state enum type (IDLE/BUSY/DONE) and the default WIDTH constant.
REQ-027: Sub-module seq_mult_datapath SHALL hold the operand shift registers and accumulator; the FSM and step counter SHALL stay in seq_multiplier.

Verification (WIDTH=4)
REQ-028: a=15, b=15, start one cycle -> busy 4 cycles, done pulse, product=225.
REQ-029: Exhaustive sweep of a,b in 0..15 -> every product equals a*b.
REQ-030: a=9, b=6, then start held through DONE with a=3, b=5 -> products 54 then 15, with no IDLE cycle between them.
REQ-031: Start pulsed mid-BUSY with different operands -> ignored; original product returned on the original done cycle.
REQ-032: rst_n low on the 2nd BUSY cycle -> next edge busy=0, done=0, product=0; no done pulse follows.
REQ-033: With SEQ_MULT_EARLY_EXIT_EN defined: a=7, b=1 -> busy 1 cycle, product=7; a=7, b=8 -> busy 4 cycles, product=56.
